text_term_ctrl: RTL



---
 rtl/text_term_pkg.sv | 12 +
 rtl/text_term_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/text_term_pkg.sv
// text_term_pkg: control codes, FSM state type and default geometry for text_term_ctrl.
package text_term_pkg;
  localparam logic [7:0] CC_BS = 8'h08;
  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_FF = 8'h0C;
  localparam logic [7:0] CC_CR = 8'h0D;
  localparam int DEF_COLS = 40;
  localparam int DEF_ROWS = 25;
  localparam int DEF_ADDR_W = 10;
  localparam logic [7:0] DEF_FILL = 8'h20;
  typedef enum logic [2:0] {CLEAR, IDLE, PUT, SCROLL_RD, SCROLL_WR, SCROLL_FILL} state_t;
endpackage

// File: rtl/text_term_ctrl.sv
// text_term_ctrl: byte-stream terminal writer for the text-mode character memory.
// Optional macro TEXT_TERM_FF_CLEAR_EN makes 0x0C clear the screen and home the cursor.
import text_term_pkg::*;
module text_term_ctrl #(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter logic [7:0] FILL = DEF_FILL
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_q,
  output logic [5:0]        cursor_col,
  output logic [4:0]        cursor_row,
  output logic              busy
);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LAST_ROW_A = ADDR_W'(COLS * (ROWS - 1));
  localparam logic [ADDR_W-1:0] LAST_CP = ADDR_W'(COLS * (ROWS - 1) - 1);
  localparam logic [5:0] LAST_COL = 6'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  function automatic logic is_ctl(input logic [7:0] b);
`ifdef TEXT_TERM_FF_CLEAR_EN
    return b == CC_CR || b == CC_LF || b == CC_BS || b == CC_FF;
`else
    return b == CC_CR || b == CC_LF || b == CC_BS;
`endif
  endfunction
  state_t state;
  logic [7:0] byte_r, wdata_r;
  logic [ADDR_W-1:0] cur_a;
  logic adv;
  assign in_ready = state == IDLE;
  assign busy = state != IDLE;
  // scroll writes forward the synchronous read data of the previous cycle
  assign mem_wdata = state == SCROLL_WR ? mem_q : wdata_r;
  assign adv = byte_r == CC_LF || (!is_ctl(byte_r) && cursor_col == LAST_COL);
  // mem_we/mem_addr are registered so they line up with the state that owns them
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= CLEAR;
      byte_r <= '0;
      wdata_r <= FILL;
      mem_we <= 1'b0;
      mem_addr <= '0;
      cur_a <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
    end else begin
      case (state)
        CLEAR:
          if (!mem_we) begin
            mem_we <= 1'b1;
            mem_addr <= '0;
            wdata_r <= FILL;
          end else if (mem_addr == LAST_A) begin
            mem_we <= 1'b0;
            state <= IDLE;
            cur_a <= '0;
            cursor_col <= '0;
            cursor_row <= '0;
          end else mem_addr <= mem_addr + 1'b1;
        IDLE:
          if (in_valid) begin
            byte_r <= in_data;
            state <= PUT;
            if (!is_ctl(in_data)) begin
              mem_we <= 1'b1;
              mem_addr <= cur_a;
              wdata_r <= in_data;
            end
          end
        PUT: begin
          mem_we <= 1'b0;
          state <= IDLE;
          if (adv) begin
            cursor_col <= '0;
            if (cursor_row == LAST_ROW) begin
              cur_a <= LAST_ROW_A;
              mem_addr <= COLS_A;
              state <= SCROLL_RD;
            end else begin
              cursor_row <= cursor_row + 1'b1;
              cur_a <= cur_a - ADDR_W'(cursor_col) + COLS_A;
            end
          end else if (byte_r == CC_CR) begin
            cursor_col <= '0;
            cur_a <= cur_a - ADDR_W'(cursor_col);
          end else if (byte_r == CC_BS) begin
            if (cursor_col != '0) begin
              cursor_col <= cursor_col - 1'b1;
              cur_a <= cur_a - 1'b1;
            end
`ifdef TEXT_TERM_FF_CLEAR_EN
          end else if (byte_r == CC_FF) begin
            state <= CLEAR;
`endif
          end else begin
            cursor_col <= cursor_col + 1'b1;
            cur_a <= cur_a + 1'b1;
          end
        end
        SCROLL_RD: begin
          mem_addr <= mem_addr - COLS_A;
          mem_we <= 1'b1;
          state <= SCROLL_WR;
        end
        SCROLL_WR:
          if (mem_addr == LAST_CP) begin
            mem_addr <= LAST_ROW_A;
            wdata_r <= FILL;
            state <= SCROLL_FILL;
          end else begin
            mem_addr <= mem_addr + COLS_A + 1'b1;
            mem_we <= 1'b0;
            state <= SCROLL_RD;
          end
        SCROLL_FILL:
          if (mem_addr == LAST_A) begin
            mem_we <= 1'b0;
            state <= IDLE;
          end else mem_addr <= mem_addr + 1'b1;
        default: state <= CLEAR;
      endcase
    end
  end
endmodule
